// File: rtl/mem_map_pkg.sv
// Memory map constants and FSM state type
// shared by the bus arbiter and its decoder.
package mem_map_pkg;
   localparam logic [31:0] GPIO_OUT_ADDR = 32'h1001_0024;
   localparam logic [31:0] GPIO_IN_ADDR  = 32'h1001_0028;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;
endpackage

// File: rtl/mem_target_decode.sv
// Address/direction decode: selects GPIO
// for its two registers, RAM for all else.
import mem_map_pkg::*;

module mem_target_decode #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic              re,
   output logic              gpio_sel
);
   logic hit_out;
   logic hit_in;

   assign hit_out  = (addr == ADDR_W'(GPIO_OUT_ADDR));
   assign hit_in   = (addr == ADDR_W'(GPIO_IN_ADDR));
   assign gpio_sel = (hit_out && we) || (hit_in && re);
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter routing
// single transactions to RAM or GPIO.
import mem_map_pkg::*;

module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic              m0_re_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic              m1_re_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              ram_we_o,
   output logic              ram_re_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic              gpio_we_o,
   output logic              gpio_re_o,
   output logic [ADDR_W-1:0] gpio_addr_o,
   output logic [DATA_W-1:0] gpio_wdata_o,
   input  logic [DATA_W-1:0] gpio_rdata_i,
   output logic              busy_o,
   output logic              owner_o
);
   state_t            state;
   logic              last_grant;
   logic              gnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              re_q;
   logic              gpio_q;

   logic              gnt_next;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic              sel_re;
   logic              sel_gpio;
   logic [DATA_W-1:0] rsp_data;

   // Contention goes to the master that was not served last.
   assign gnt_next  = (m0_req_i && m1_req_i) ? ~last_grant : m1_req_i;
   assign sel_addr  = gnt_next ? m1_addr_i  : m0_addr_i;
   assign sel_wdata = gnt_next ? m1_wdata_i : m0_wdata_i;
   assign sel_we    = gnt_next ? m1_we_i    : m0_we_i;
   // A combined write+read request is executed as a write only.
   assign sel_re    = (gnt_next ? m1_re_i : m0_re_i) & ~sel_we;

   mem_target_decode #(
      .ADDR_W(ADDR_W)
   ) u_decode (
      .addr    (sel_addr),
      .we      (sel_we),
      .re      (sel_re),
      .gpio_sel(sel_gpio)
   );

   assign rsp_data = !re_q  ? '0 :
                     gpio_q ? gpio_rdata_i : ram_rdata_i;

   assign ram_addr_o   = addr_q;
   assign ram_wdata_o  = wdata_q;
   assign gpio_addr_o  = addr_q;
   assign gpio_wdata_o = wdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner_o    <= 1'b0;
         gnt        <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         gpio_q     <= 1'b0;
         busy_o     <= 1'b0;
         ram_we_o   <= 1'b0;
         ram_re_o   <= 1'b0;
         gpio_we_o  <= 1'b0;
         gpio_re_o  <= 1'b0;
         m0_ack_o   <= 1'b0;
         m1_ack_o   <= 1'b0;
         m0_rdata_o <= '0;
         m1_rdata_o <= '0;
      end else begin
         ram_we_o   <= 1'b0;
         ram_re_o   <= 1'b0;
         gpio_we_o  <= 1'b0;
         gpio_re_o  <= 1'b0;
         m0_ack_o   <= 1'b0;
         m1_ack_o   <= 1'b0;
         m0_rdata_o <= '0;
         m1_rdata_o <= '0;
         unique case (state)
            IDLE: begin
               if (m0_req_i || m1_req_i) begin
                  gnt       <= gnt_next;
                  addr_q    <= sel_addr;
                  wdata_q   <= sel_wdata;
                  we_q      <= sel_we;
                  re_q      <= sel_re;
                  gpio_q    <= sel_gpio;
                  ram_we_o  <= sel_we & ~sel_gpio;
                  ram_re_o  <= sel_re & ~sel_gpio;
                  gpio_we_o <= sel_we & sel_gpio;
                  gpio_re_o <= sel_re & sel_gpio;
                  busy_o    <= 1'b1;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (gnt) begin
                  m1_ack_o   <= 1'b1;
                  m1_rdata_o <= rsp_data;
               end else begin
                  m0_ack_o   <= 1'b1;
                  m0_rdata_o <= rsp_data;
               end
               last_grant <= gnt;
               owner_o    <= gnt;
               state      <= RESP;
            end
            RESP: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for the
// two-master memory bus arbiter.
module tb_mem_bus_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m0_re;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m0_ack;
   logic        m1_req, m1_we, m1_re;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        m1_ack;
   logic        ram_we, ram_re, gpio_we, gpio_re;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [31:0] gpio_addr, gpio_wdata, gpio_rdata;
   logic        busy, owner;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_re_i(m0_re),
      .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_re_i(m1_re),
      .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
      .ram_we_o(ram_we), .ram_re_o(ram_re),
      .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
      .ram_rdata_i(ram_rdata),
      .gpio_we_o(gpio_we), .gpio_re_o(gpio_re),
      .gpio_addr_o(gpio_addr), .gpio_wdata_o(gpio_wdata),
      .gpio_rdata_i(gpio_rdata),
      .busy_o(busy), .owner_o(owner)
   );

   task automatic clear_masters();
      m0_req = 0; m0_we = 0; m0_re = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_re = 0; m1_addr = 0; m1_wdata = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_masters();
      repeat (2) @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (busy !== 1'b0) begin n_fail++;
         $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if ({ram_we, ram_re, gpio_we, gpio_re} !== 4'b0) begin n_fail++;
         $display("FAIL reset_strobes got %b want 0000", {ram_we, ram_re, gpio_we, gpio_re}); end
      n_cmp++; if ({m0_ack, m1_ack} !== 2'b0 || m0_rdata !== 0 || m1_rdata !== 0) begin n_fail++;
         $display("FAIL reset_acks got %b %h %h want 0", {m0_ack, m1_ack}, m0_rdata, m1_rdata); end
      n_cmp++; if (owner !== 1'b0) begin n_fail++;
         $display("FAIL reset_owner got %b want 0", owner); end
   endtask

   task automatic test_gpio_write();
      m0_req = 1; m0_we = 1; m0_addr = 32'h1001_0024; m0_wdata = 32'hA5;
      @(negedge clk);
      n_cmp++; if ({gpio_we, gpio_re, ram_we, ram_re} !== 4'b1000) begin n_fail++;
         $display("FAIL gw_strobes got %b want 1000", {gpio_we, gpio_re, ram_we, ram_re}); end
      n_cmp++; if (gpio_wdata !== 32'hA5 || gpio_addr !== 32'h1001_0024) begin n_fail++;
         $display("FAIL gw_payload got %h/%h want 10010024/a5", gpio_addr, gpio_wdata); end
      n_cmp++; if (m0_ack !== 1'b0 || busy !== 1'b1) begin n_fail++;
         $display("FAIL gw_access got ack %b busy %b want 0 1", m0_ack, busy); end
      m0_wdata = 32'hFF; m0_addr = 32'h0;
      @(negedge clk);
      n_cmp++; if (m0_ack !== 1'b1 || m0_rdata !== 0 || m1_ack !== 1'b0) begin n_fail++;
         $display("FAIL gw_ack got %b %h m1 %b want 1 0 0", m0_ack, m0_rdata, m1_ack); end
      n_cmp++; if (gpio_we !== 1'b0 || gpio_wdata !== 32'hA5) begin n_fail++;
         $display("FAIL gw_hold got we %b data %h want 0 a5", gpio_we, gpio_wdata); end
      clear_masters();
      @(negedge clk);
      n_cmp++; if (m0_ack !== 1'b0 || busy !== 1'b0 || owner !== 1'b0) begin n_fail++;
         $display("FAIL gw_done got ack %b busy %b own %b want 0 0 0", m0_ack, busy, owner); end
   endtask

   task automatic test_gpio_read();
      gpio_rdata = 32'h3;
      m1_req = 1; m1_re = 1; m1_addr = 32'h1001_0028;
      @(negedge clk);
      n_cmp++; if ({gpio_we, gpio_re, ram_we, ram_re} !== 4'b0100) begin n_fail++;
         $display("FAIL gr_strobes got %b want 0100", {gpio_we, gpio_re, ram_we, ram_re}); end
      n_cmp++; if (m1_ack !== 1'b0) begin n_fail++;
         $display("FAIL gr_early_ack got %b want 0", m1_ack); end
      @(negedge clk);
      n_cmp++; if (m1_ack !== 1'b1 || m1_rdata !== 32'h3) begin n_fail++;
         $display("FAIL gr_ack got %b %h want 1 3", m1_ack, m1_rdata); end
      n_cmp++; if (m0_ack !== 1'b0 || m0_rdata !== 0 || owner !== 1'b1) begin n_fail++;
         $display("FAIL gr_other got %b %h own %b want 0 0 1", m0_ack, m0_rdata, owner); end
      clear_masters();
      @(negedge clk);
      n_cmp++; if (m1_ack !== 1'b0 || m1_rdata !== 0) begin n_fail++;
         $display("FAIL gr_clear got %b %h want 0 0", m1_ack, m1_rdata); end
   endtask

   task automatic test_ram_route();
      ram_rdata = 32'hDEAD_BEEF;
      m0_req = 1; m0_re = 1; m0_addr = 32'h1001_0024;
      @(negedge clk);
      n_cmp++; if ({gpio_we, gpio_re, ram_we, ram_re} !== 4'b0001) begin n_fail++;
         $display("FAIL rr_strobes got %b want 0001", {gpio_we, gpio_re, ram_we, ram_re}); end
      n_cmp++; if (ram_addr !== 32'h1001_0024) begin n_fail++;
         $display("FAIL rr_addr got %h want 10010024", ram_addr); end
      @(negedge clk);
      n_cmp++; if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin n_fail++;
         $display("FAIL rr_ack got %b %h want 1 deadbeef", m0_ack, m0_rdata); end
      clear_masters();
      @(negedge clk);
   endtask

   task automatic test_odd_dirs();
      m1_req = 1; m1_we = 1; m1_re = 1;
      m1_addr = 32'h1001_0028; m1_wdata = 32'h77;
      @(negedge clk);
      n_cmp++; if ({gpio_we, gpio_re, ram_we, ram_re} !== 4'b0010) begin n_fail++;
         $display("FAIL wr_both got %b want 0010", {gpio_we, gpio_re, ram_we, ram_re}); end
      @(negedge clk);
      n_cmp++; if (m1_ack !== 1'b1 || m1_rdata !== 0) begin n_fail++;
         $display("FAIL wr_both_ack got %b %h want 1 0", m1_ack, m1_rdata); end
      clear_masters();
      @(negedge clk);
      m0_req = 1; m0_addr = 32'h40;
      @(negedge clk);
      n_cmp++; if ({gpio_we, gpio_re, ram_we, ram_re} !== 4'b0 || busy !== 1'b1) begin n_fail++;
         $display("FAIL nop_strobes got %b busy %b want 0000 1", {gpio_we, gpio_re, ram_we, ram_re}, busy); end
      @(negedge clk);
      n_cmp++; if (m0_ack !== 1'b1 || m0_rdata !== 0) begin n_fail++;
         $display("FAIL nop_ack got %b %h want 1 0", m0_ack, m0_rdata); end
      clear_masters();
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int seen = 0;
      int last_c = -1;
      logic want = 1'b0;
      do_reset();
      m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'h11;
      m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h22;
      for (int c = 0; c < 40 && seen < 4; c++) begin
         @(negedge clk);
         if (m0_ack || m1_ack) begin
            n_cmp++; if (m0_ack === m1_ack || m1_ack !== want) begin n_fail++;
               $display("FAIL rr_order[%0d] got m0 %b m1 %b want m%0d", seen, m0_ack, m1_ack, want); end
            if (last_c >= 0) begin
               n_cmp++; if (c - last_c != 3) begin n_fail++;
                  $display("FAIL rr_gap[%0d] got %0d want 3", seen, c - last_c); end
            end
            last_c = c;
            want = ~want;
            seen++;
         end
      end
      n_cmp++; if (seen != 4) begin n_fail++;
         $display("FAIL rr_count got %0d want 4", seen); end
      clear_masters();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int hit = 0;
      m1_req = 1; m1_we = 1; m1_addr = 32'h300; m1_wdata = 32'h33;
      @(negedge clk);
      n_cmp++; if (ram_we !== 1'b1) begin n_fail++;
         $display("FAIL ab_access got %b want 1", ram_we); end
      reset = 1;
      @(negedge clk);
      n_cmp++; if (ram_we !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0) begin n_fail++;
         $display("FAIL ab_abort got we %b ack %b busy %b want 0 0 0", ram_we, m1_ack, busy); end
      reset = 0;
      m0_req = 1; m0_we = 1; m0_addr = 32'h400; m0_wdata = 32'h44;
      for (int c = 0; c < 10 && hit == 0; c++) begin
         @(negedge clk);
         if (m0_ack || m1_ack) begin
            hit = 1;
            n_cmp++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin n_fail++;
               $display("FAIL ab_first got m0 %b m1 %b want m0", m0_ack, m1_ack); end
         end
      end
      n_cmp++; if (hit == 0) begin n_fail++;
         $display("FAIL ab_timeout got no ack want ack"); end
      clear_masters();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset = 1;
      ram_rdata = 0;
      gpio_rdata = 0;
      clear_masters();
      test_reset();
      test_gpio_write();
      test_gpio_read();
      test_ram_route();
      test_odd_dirs();
      test_round_robin();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
